// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan bus monitor decoding the display back to BCD MM:SS
// Define SEG_DECODE_HEX_EN to also decode the A-F glyphs.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic [6:0]  seg,
   input  logic [7:0]  an,
   input  logic        err_clr,
   output logic [15:0] mm_ss,
   output logic        frame_valid,
   output logic        digit_err,
   output logic        blank
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 1);

   logic [7:0]    an_meta, an_sync;
   logic [6:0]    seg_meta, seg_sync;
   logic [14:0]   prev_sample;
   logic [SW-1:0] stab_cnt, stab_next;
   logic [TW-1:0] dark_cnt;
   logic          accepted;
   logic [3:0]    mask, mask_next;
   logic [15:0]   shadow;
   logic          changed, sel_valid, sel_dark;
   logic [1:0]    sel_idx;
   logic          dec_ok;
   logic [3:0]    dec_val;
   logic          acc_hit, blank_hit;

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'd0;
      case (seg_sync)
         7'b0000001: dec_val = 4'd0;
         7'b1001111: dec_val = 4'd1;
         7'b0010010: dec_val = 4'd2;
         7'b0000110: dec_val = 4'd3;
         7'b1001100: dec_val = 4'd4;
         7'b0100100: dec_val = 4'd5;
         7'b0100000: dec_val = 4'd6;
         7'b0001111: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0000100: dec_val = 4'd9;
`ifdef SEG_DECODE_HEX_EN
         7'b0001000: dec_val = 4'hA;
         7'b1100000: dec_val = 4'hB;
         7'b0110001: dec_val = 4'hC;
         7'b1000010: dec_val = 4'hD;
         7'b0110000: dec_val = 4'hE;
         7'b0111000: dec_val = 4'hF;
`endif
         default:    dec_ok  = 1'b0;
      endcase
   end

   // Exactly one low anode among the four digit lines, upper lines all high.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = 2'd0;
      sel_dark  = (an_sync == 8'hFF);
      case (an_sync)
         8'hFE:   begin sel_valid = 1'b1; sel_idx = 2'd0; end
         8'hFD:   begin sel_valid = 1'b1; sel_idx = 2'd1; end
         8'hFB:   begin sel_valid = 1'b1; sel_idx = 2'd2; end
         8'hF7:   begin sel_valid = 1'b1; sel_idx = 2'd3; end
         default: sel_valid = 1'b0;
      endcase
   end

   always_comb begin
      changed = ({an_sync, seg_sync} != prev_sample);
      if (!sel_valid)
         stab_next = '0;
      else if (changed)
         stab_next = SW'(1);
      else if (stab_cnt != STABLE_MAX)
         stab_next = stab_cnt + SW'(1);
      else
         stab_next = stab_cnt;
      // Accept on the cycle the run length reaches the threshold, once per steady pattern.
      acc_hit   = sel_valid && (stab_next == STABLE_MAX) && !(accepted && !changed);
      blank_hit = sel_dark && (dark_cnt == TIMEOUT_PRE);
      mask_next = ((mask == 4'hF) || blank_hit) ? 4'h0 : mask;
      if (acc_hit && dec_ok)
         mask_next[sel_idx] = 1'b1;
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         an_meta     <= '1;
         an_sync     <= '1;
         seg_meta    <= '1;
         seg_sync    <= '1;
         prev_sample <= '1;
         stab_cnt    <= '0;
         dark_cnt    <= '0;
         accepted    <= 1'b0;
         mask        <= 4'h0;
         shadow      <= 16'h0000;
         mm_ss       <= 16'h0000;
         frame_valid <= 1'b0;
         digit_err   <= 1'b0;
         blank       <= 1'b0;
      end else begin
         an_meta     <= an;
         an_sync     <= an_meta;
         seg_meta    <= seg;
         seg_sync    <= seg_meta;
         prev_sample <= {an_sync, seg_sync};
         stab_cnt    <= stab_next;
         mask        <= mask_next;
         frame_valid <= 1'b0;

         if (acc_hit)
            accepted <= 1'b1;
         else if (changed)
            accepted <= 1'b0;

         if (sel_valid)
            dark_cnt <= '0;
         else if (sel_dark && (dark_cnt != TIMEOUT_MAX))
            dark_cnt <= dark_cnt + TW'(1);

         if (acc_hit && dec_ok)
            shadow[{sel_idx, 2'b00} +: 4] <= dec_val;

         if (mask == 4'hF) begin
            mm_ss       <= shadow;
            frame_valid <= 1'b1;
         end

         if (acc_hit)
            blank <= 1'b0;
         else if (blank_hit)
            blank <= 1'b1;

         if (acc_hit && !dec_ok)
            digit_err <= 1'b1;
         else if (err_clr)
            digit_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized bench with a dwell-level reference model for seg_scan_decoder
module tb_seg_scan_decoder;
   localparam int STABLE = 8;
   localparam int TMO    = 300;

   logic        clk_in  = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  seg     = 7'h7F;
   logic [7:0]  an      = 8'hFF;
   logic        err_clr = 1'b0;
   logic [15:0] mm_ss;
   logic        frame_valid, digit_err, blank;

   seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_in(clk_in), .reset_n(reset_n), .seg(seg), .an(an), .err_clr(err_clr),
      .mm_ss(mm_ss), .frame_valid(frame_valid), .digit_err(digit_err), .blank(blank)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int          fv_cnt = 0;
   always @(negedge clk_in)
      if (frame_valid === 1'b1) fv_cnt++;

   logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                            7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   logic [7:0] an_tab [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

   function automatic int dec_model(input logic [6:0] s);
      int lim;
      lim = 10;
`ifdef SEG_DECODE_HEX_EN
      lim = 16;
`endif
      for (int i = 0; i < lim; i++)
         if (pat[i] == s) return i;
      return -1;
   endfunction

   // Model state: what the display has shown, tracked per dwell rather than per cycle.
   int          m_sh [4];
   logic [3:0]  m_mask;
   logic [15:0] m_mm;
   bit          m_err, m_blank, m_acc;
   int          m_frames = 0;
   logic [14:0] m_prev;
   int          m_run, m_dark;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_sh[k] = 0;
      m_mask = 4'h0; m_mm = 16'h0; m_err = 0; m_blank = 0; m_acc = 0;
      m_prev = 15'h7FFF; m_run = 0; m_dark = 0;
   endtask

   task automatic model_dwell(input logic [7:0] a, input logic [6:0] s, input int len, input int clr_at);
      bit dark, valid, acc_now;
      int idx, v;
      dark = (a == 8'hFF);
      valid = 0; idx = 0; acc_now = 0;
      if (a[7:4] == 4'hF)
         for (int k = 0; k < 4; k++)
            if (a[3:0] == 4'(~(1 << k))) begin valid = 1; idx = k; end
      if ({a, s} == m_prev) m_run += len;
      else begin m_run = len; m_acc = 0; end
      m_prev = {a, s};
      if (dark) begin
         if (m_dark < TMO && m_dark + len >= TMO) begin m_blank = 1; m_mask = 4'h0; end
         m_dark = (m_dark + len > TMO) ? TMO : m_dark + len;
      end else if (valid) begin
         m_dark = 0;
         if (!m_acc && m_run >= STABLE) begin m_acc = 1; acc_now = 1; end
      end
      if (clr_at >= 0 && !(acc_now && clr_at > STABLE + 1)) m_err = 0;
      if (acc_now) begin
         m_blank = 0;
         v = dec_model(s);
         if (v < 0) m_err = 1;
         else begin
            m_sh[idx] = v;
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
               m_mm = {m_sh[3][3:0], m_sh[2][3:0], m_sh[1][3:0], m_sh[0][3:0]};
               m_frames++;
               m_mask = 4'h0;
            end
         end
      end
      if (clr_at >= 0 && acc_now && clr_at > STABLE + 1) m_err = 0;
   endtask

   // probe 1: blank falls on the acceptance edge; probe 2: frame pulse one cycle after acceptance.
   task automatic drive_dwell(input logic [7:0] a, input logic [6:0] s, input int len,
                              input int clr_at, input int probe);
      model_dwell(a, s, len, clr_at);
      an = a; seg = s;
      for (int i = 0; i < len; i++) begin
         err_clr = (i == clr_at);
         @(posedge clk_in); #1;
         if (probe == 1 && i == STABLE)     check_eq("blank_hold", blank, 1);
         if (probe == 1 && i == STABLE + 1) check_eq("blank_fall", blank, 0);
         if (probe == 2 && i == STABLE + 1) check_eq("fv_early", frame_valid, 0);
         if (probe == 2 && i == STABLE + 2) begin
            check_eq("fv_pulse", frame_valid, 1);
            check_eq("fv_mm", mm_ss, m_mm);
         end
      end
      err_clr = 1'b0;
   endtask

   task automatic settle(input int len);
      drive_dwell(8'hFF, 7'h7F, len, -1, 0);
   endtask

   task automatic digit(input int slot, input int val, input int len, input int probe);
      drive_dwell(an_tab[slot], pat[val], len, -1, probe);
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_frames"}, fv_cnt, m_frames);
      check_eq({tag, "_mm"}, mm_ss, m_mm);
      check_eq({tag, "_err"}, digit_err, m_err);
      check_eq({tag, "_blank"}, blank, m_blank);
   endtask

   task automatic do_reset();
      an = 8'hFF; seg = 7'h7F;
      reset_n = 1'b0;
      @(posedge clk_in); #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int r, slot, len;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1 reset_n = 1'b1;
      check_eq("rst_fv", frame_valid, 0);
      check_state("rst");

      // 02:59 scanned tens-of-minutes first
      digit(3, 0, 20, 0);
      digit(2, 2, 20, 0);
      digit(1, 5, 20, 0);
      digit(0, 9, 20, 2);
      settle(6);
      check_eq("t1_mm", mm_ss, 16'h0259);
      check_state("t1");

      for (int sc = 0; sc < 3; sc++)
         for (int k = 3; k >= 0; k--) digit(k, $urandom_range(0, 9), STABLE - 1, 0);
      settle(6);
      check_eq("short_mm", mm_ss, 16'h0259);
      check_eq("short_err", digit_err, 0);
      check_state("short");

      for (int k = 3; k >= 0; k--) digit(k, $urandom_range(0, 9), 20, 0);
      digit(0, $urandom_range(0, 9), 20, 0);
      digit(1, $urandom_range(0, 9), 20, 0);
      settle(TMO + 5);
      check_eq("blank_on", blank, 1);
      check_state("blank");
      digit(2, $urandom_range(0, 9), 20, 1);
      digit(3, $urandom_range(0, 9), 20, 0);
      digit(0, $urandom_range(0, 9), 20, 0);
      settle(6);
      check_state("resume3");
      digit(1, $urandom_range(0, 9), 20, 2);
      settle(6);
      check_state("resume4");

      drive_dwell(8'hFD, 7'h7F, 20, -1, 0);
      settle(6);
      check_eq("bad_err", digit_err, 1);
      settle(10);
      check_state("bad_sticky");
      drive_dwell(8'hFF, 7'h7F, 4, 1, 0);
      check_eq("clr_err", digit_err, 0);
      drive_dwell(8'hFB, 7'h7F, 20, STABLE + 1, 0);
      settle(6);
      check_eq("clr_race_err", digit_err, 1);
      check_state("clr_race");

      digit(3, 1, 20, 0);
      digit(2, 4, 20, 0);
      digit(1, 3, 20, 0);
      settle(3);
      do_reset();
      digit(0, 7, 20, 0);
      settle(6);
      check_eq("rst_mid_mm", mm_ss, 16'h0000);
      check_state("rst_mid");

      for (int k = 3; k >= 0; k--) drive_dwell(an_tab[k], 7'b0110000, 20, -1, 0);
      settle(6);
`ifdef SEG_DECODE_HEX_EN
      check_eq("hex_mm", mm_ss, 16'hEEEE);
      check_eq("hex_err", digit_err, 0);
`else
      check_eq("hex_err", digit_err, 1);
      check_eq("hex_mm", mm_ss, 16'h0000);
`endif
      check_state("hex");

      for (int rnd = 0; rnd < 5; rnd++) begin
         for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
               drive_dwell(8'hFF, 7'h7F, $urandom_range(1, 8), -1, 0);
            else if (r == 1)
               drive_dwell(8'($urandom), 7'($urandom), $urandom_range(1, 12), -1, 0);
            else if (r == 2)
               drive_dwell(an_tab[$urandom_range(0, 3)], 7'($urandom), $urandom_range(STABLE - 2, STABLE + 4), -1, 0);
            else begin
               slot = $urandom_range(0, 3);
               len  = $urandom_range(STABLE - 2, STABLE + 4);
               digit(slot, $urandom_range(0, 9), len, 0);
            end
         end
         settle(6);
         check_state("rand");
         drive_dwell(8'hFF, 7'h7F, 2, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the multiplexed seven-segment scan bus driven by the egg timer display logic. It samples the active-low segment and anode lines, waits for each digit to hold steady, and converts the segment patterns back to BCD. It assembles the four digits into an MM:SS word and flags blanked (flashing) displays and undecodable patterns. It sits on the board-level test/monitor path, next to the timer, observing the same seg/an pins.

## Interface
- STABLE_CYCLES, 8 — consecutive identical samples required before a digit is accepted (≥2).
- TIMEOUT_CYCLES, 20000 — consecutive cycles with no digit enabled before `blank` asserts.

- clk_in  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- seg  input  7  active-low segments; seg[6]=a … seg[0]=g ('0' = 7'b0000001).
- an  input  8  active-low anodes; an[0]=sec ones, an[1]=sec tens, an[2]=min ones, an[3]=min tens.
- err_clr  input  1  synchronous clear of `digit_err`.
- mm_ss  output  16  {min tens, min ones, sec tens, sec ones}, BCD.
- frame_valid  output  1  one-cycle pulse when `mm_ss` is updated.
- digit_err  output  1  sticky; an undecodable pattern was accepted.
- blank  output  1  level; the display is currently dark.

## Operation
- `seg` and `an` pass through a 2-flop synchronizer before any use.
- Digit select:
  - Valid only when an[7:4]=1111 and an[3:0] has exactly one zero.
  - an[3:0]=1111 is "dark".
  - Any other pattern is "invalid": it resets the stability counter, captures nothing, and does not advance the blank counter.
- Stability:
  - A counter increments while the synchronized {an,seg} equals the previous sample.
  - Any change reloads it to 1.
  - When it reaches STABLE_CYCLES with a valid select, the digit is accepted once. An `accepted` flag blocks re-acceptance until {an,seg} changes.
- Decode (digits 0–9): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Undecodable pattern:
  - Sets `digit_err`.
  - The digit slot and its capture bit are left unchanged.
- Capture:
  - An accepted digit writes its shadow slot and sets its bit in a 4-bit capture mask.
  - Capture order is free. Re-capturing a slot overwrites it.
- Frame:
  - When the mask becomes 1111, the shadow is copied to `mm_ss` and `frame_valid` pulses.
  - The mask clears in that same cycle.
- Blank:
  - A saturating counter runs while the select is dark and resets on any valid select.
  - At TIMEOUT_CYCLES: `blank`=1 and the capture mask clears. The shadow is kept; `mm_ss` is unchanged.
  - `blank` falls in the cycle the next digit is accepted.
- `err_clr` clears `digit_err`. If `err_clr` coincides with a new error, the set wins.
- Reset values: `mm_ss`=0, `frame_valid`=0, `digit_err`=0, `blank`=0. The counters, mask, shadow and `accepted` flag are also cleared.
- Reset asserted mid-frame discards the partial frame.

## Timing
- Acceptance: 2 cycles (synchronizer) + STABLE_CYCLES after the {an,seg} change, then 1 register stage to the shadow/mask.
- `frame_valid` and the new `mm_ss` appear in the same cycle, 1 cycle after the fourth acceptance.
- `blank` rises 2 + TIMEOUT_CYCLES cycles after `an[3:0]` goes to 1111 at the pins.
- Simultaneous fourth acceptance and blank timeout cannot occur: the select is either valid or dark, never both.
- A dwell shorter than STABLE_CYCLES is ignored silently, with no error.

## Configuration
- SEG_DECODE_HEX_EN:
  - Defined: patterns A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 decode to 4'hA–4'hF without error.
  - Undefined: these patterns set `digit_err` like any other unknown pattern.

## Test plan
- Scan 0000001@an=11110111, 0010010@11111011, 0100100@11111101, 0000100@11111110, each held 20 cycles -> one `frame_valid` pulse, `mm_ss`=16'h0259.
- Hold each digit for only STABLE_CYCLES−1 samples across several scans -> no `frame_valid`, `mm_ss` unchanged, `digit_err`=0.
- Drive an=11111111 for TIMEOUT_CYCLES+5 after a complete frame -> `blank`=1, `mm_ss` retained. Resume scanning -> `blank`=0 at the first acceptance; the next `frame_valid` follows a full four-digit scan.
- Hold seg=1111111 on an[1] for 20 cycles -> `digit_err`=1 and stays 1. Pulse `err_clr` -> 0. Pulse `err_clr` in the acceptance cycle of another bad pattern -> stays 1.
- Capture three digits, then assert reset_n=0 for 1 cycle, then supply only the fourth digit -> no `frame_valid`, all outputs at reset values.
- Scan E (0110000) on all digits: with SEG_DECODE_HEX_EN -> `mm_ss`=16'hEEEE and `digit_err`=0; without it -> `digit_err`=1 and no frame.
